fetch_unit: RTL
===============

# fetch_unit

Instruction fetch front end sitting directly upstream of the boot instruction ROM. It owns the program counter and drives the ROM chip-enable and word address. It captures each returned instruction word together with its PC into a small FIFO, and presents them to decode through a valid/ready handshake. It also handles PC redirects from execute by flushing buffered words and restarting fetch.

## Interface
- RESET_PC, 64'h0: byte PC loaded on reset; must be 4-byte aligned.
- FIFO_DEPTH, 4: instruction FIFO entries; power of two, 2..16.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active low (rst==0 at a rising edge resets)
- rom_ce  out  1  ROM enable; high while a fetch is outstanding
- rom_addr  out  64  ROM word address = pc>>2
- rom_valid  in  1  ROM data strobe; periodic, arbitrary phase
- rom_inst  in  32  ROM data, sampled only when accepted
- redirect_valid  in  1  one-cycle request to restart fetch
- redirect_pc  in  64  new byte PC
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  decode accepts head entry
- out_inst  out  32  head instruction
- out_pc  out  64  head byte PC
- fetch_fault  out  1  misaligned redirect seen (see Configuration)

## Operation
- Registers: pc[63:0], FIFO of {pc,inst}, count[log2(FIFO_DEPTH):0], state.
- States:
  - ISSUE: rom_ce=1, rom_addr=pc>>2; rom_valid ignored; -> WAIT.
  - WAIT: rom_ce=1, address held. On rom_valid: push {pc,rom_inst}, pc<=pc+4 (64-bit wrap), -> ISSUE if post-update count<FIFO_DEPTH else HOLD.
  - HOLD: rom_ce=0; -> ISSUE when count<FIFO_DEPTH.
  - FAULT: only with macro; rom_ce=0.
- At most one fetch is outstanding at a time. A fetch is issued only with a free slot, so a push never overflows.
- Pop: out_valid&&out_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect (any state, highest priority):
  - pc<=redirect_pc, FIFO flushed (count<=0), -> ISSUE.
  - A rom_valid or pop in the same cycle is discarded.
  - The ISSUE cycle ignoring rom_valid ensures no stale word from the old address is captured.
- rom_addr is registered and stable for every cycle rom_ce is high in ISSUE/WAIT.

## Timing
- Reset values: rom_ce=0, rom_addr=RESET_PC>>2, out_valid=0, out_inst=0, out_pc=0, fetch_fault=0, pc=RESET_PC, count=0, state=ISSUE (entered on the first edge with rst==1).
- Reset mid-fetch: the outstanding request is abandoned and the FIFO is emptied with no output glitch.
- Fetch latency: ISSUE cycle plus the wait to the next accepted rom_valid. With a period-4 strobe, 2..5 cycles from ISSUE to out_valid.
- A captured word appears on out_valid/out_inst/out_pc the cycle after the accepting edge.
- Redirect: out_valid=0 the cycle after; the new pc is on rom_addr the cycle after.
- Pop-to-refetch: in HOLD, a pop makes ISSUE the next state.
- Throughput: at most one word per two cycles; ROM-strobe-limited in practice.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky), flushes the FIFO and enters FAULT.
  - The next aligned redirect clears fetch_fault and -> ISSUE.
  - RESET_PC alignment is not checked in hardware.
- Not defined: redirect_pc[1:0] is forced to 2'b00, FAULT is unreachable and fetch_fault is tied 0.

## Test plan
- Reset release, RESET_PC=0x1000, rom_valid every 4th cycle, out_ready=1 -> out_pc sequence 0x1000, 0x1004, 0x1008 with matching rom_inst; rom_addr 0x400, 0x401, 0x402.
- out_ready=0 with FIFO_DEPTH=4 -> exactly 4 entries captured, then HOLD with rom_ce=0. A single pop -> exactly one further fetch.
- Redirect to 0x2000 coincident with rom_valid in WAIT -> that word dropped, out_valid=0 next cycle, next out_pc=0x2000.
- rom_valid pulse in the ISSUE cycle -> ignored; the word is captured on the following pulse with the correct address.
- rst=0 asserted mid-WAIT with 3 entries -> all outputs at reset values next cycle, fetch restarts at RESET_PC.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x2002 -> fetch_fault=1, rom_ce=0. Redirect to 0x3000 -> fetch_fault=0, fetch resumes. Without the macro, the same 0x2002 redirect -> fetch from 0x2000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, drives the boot ROM and buffers {pc,inst} for decode.
// Optional misaligned-redirect fault handling is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        rom_ce,
   output logic [63:0] rom_addr,
   input  logic        rom_valid,
   input  logic [31:0] rom_inst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [63:0] out_pc,
   output logic        fetch_fault
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {ISSUE, WAIT, HOLD, FAULT} state_t;

   state_t        state;
   logic [63:0]   pc;
   logic [AW:0]   count;
   logic [AW:0]   count_nxt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [63:0]   pc_mem   [FIFO_DEPTH];
   logic [31:0]   inst_mem [FIFO_DEPTH];
   logic          fault_q;
   logic          push;
   logic          pop;
   logic [63:0]   redir_pc;
   logic          redir_bad;

   always_comb begin
      push      = rst && (state == WAIT) && rom_valid && !redirect_valid;
      pop       = out_valid && out_ready && !redirect_valid;
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + (AW + 1)'(1);
      else if (!push && pop)
         count_nxt = count - (AW + 1)'(1);
`ifdef FETCH_MISALIGN_CHECK_EN
      redir_pc  = redirect_pc;
      redir_bad = |redirect_pc[1:0];
`else
      redir_pc  = redirect_pc & ~64'd3;
      redir_bad = 1'b0;
`endif
   end

   assign out_valid   = (count != '0);
   assign out_inst    = out_valid ? inst_mem[rd_ptr] : '0;
   assign out_pc      = out_valid ? pc_mem[rd_ptr]   : '0;
   assign fetch_fault = fault_q;

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= pc;
         inst_mem[wr_ptr] <= rom_inst;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ISSUE;
         pc       <= RESET_PC;
         rom_ce   <= 1'b0;
         rom_addr <= RESET_PC >> 2;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fault_q  <= 1'b0;
      end else if (redirect_valid) begin
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         pc      <= redir_pc;
         fault_q <= redir_bad;
         if (redir_bad) begin
            state  <= FAULT;
            rom_ce <= 1'b0;
         end else begin
            state    <= ISSUE;
            rom_ce   <= 1'b1;
            rom_addr <= redir_pc >> 2;
         end
      end else begin
         count <= count_nxt;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case (state)
            // Reset parks in ISSUE with rom_ce low; the first live edge presents the ISSUE cycle.
            ISSUE: begin
               rom_ce <= 1'b1;
               if (rom_ce)
                  state <= WAIT;
            end
            WAIT: begin
               if (rom_valid) begin
                  pc <= pc + 64'd4;
                  if (count_nxt < DEPTH_C) begin
                     state    <= ISSUE;
                     rom_addr <= (pc + 64'd4) >> 2;
                  end else begin
                     state  <= HOLD;
                     rom_ce <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (count_nxt < DEPTH_C) begin
                  state    <= ISSUE;
                  rom_ce   <= 1'b1;
                  rom_addr <= pc >> 2;
               end
            end
            FAULT: rom_ce <= 1'b0;
            default: begin
               state  <= ISSUE;
               rom_ce <= 1'b0;
            end
         endcase
      end
   end

endmodule
